// File: rtl/id_reg_arbiter_pkg.sv
// Shared constants and types for the identification register arbiter.
package id_reg_arbiter_pkg;

   localparam logic [1:0] ADDR_ID      = 2'd0;
   localparam logic [1:0] ADDR_REV     = 2'd1;
   localparam logic [1:0] ADDR_SCRATCH = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   localparam logic [7:0] DEF_ID_VALUE  = 8'hB1;
   localparam logic [7:0] DEF_REV_VALUE = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/id_reg_arbiter_if.sv
// Requester-side bus of the ID register arbiter; rsp_par exists only with ID_PARITY_EN.
interface id_reg_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   we;
   logic [2*NREQ-1:0] addr;
   logic [8*NREQ-1:0] wdata;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_data;
   logic              rsp_err;
   logic              busy;
`ifdef ID_PARITY_EN
   logic              rsp_par;

   modport master (output req, we, addr, wdata,
                   input  rsp_valid, rsp_data, rsp_err, busy, rsp_par);
   modport slave  (input  req, we, addr, wdata,
                   output rsp_valid, rsp_data, rsp_err, busy, rsp_par);
`else
   modport master (output req, we, addr, wdata,
                   input  rsp_valid, rsp_data, rsp_err, busy);
   modport slave  (input  req, we, addr, wdata,
                   output rsp_valid, rsp_data, rsp_err, busy);
`endif
endinterface

// File: rtl/id_reg_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; one-hot plus index.
module rr_arbiter
   import id_reg_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/id_reg_arbiter.sv
// Round-robin arbiter plus ID/REV/SCRATCH/STATUS register bank, one access in flight.
// Optional ID_PARITY_EN adds a registered even-parity bit alongside rsp_data.
module id_reg_arbiter
   import id_reg_arbiter_pkg::*;
#(
   parameter int         NREQ      = 2,
   parameter logic [7:0] ID_VALUE  = DEF_ID_VALUE,
   parameter logic [7:0] REV_VALUE = DEF_REV_VALUE
) (
   input  logic          clk,
   input  logic          rst,
   id_reg_arbiter_if.slave bus
);

   localparam int IW = idx_w(NREQ);

   state_e          state, state_nx;
   logic [IW-1:0]   ptr, idx, gnt_idx;
   logic [NREQ-1:0] done, elig, gnt;
   logic            gnt_any, take;
   logic            lat_we;
   logic [1:0]      lat_addr;
   logic [7:0]      lat_wdata, scratch, status;
   logic [7:0]      rsp_data_nx;
   logic            rsp_err_nx;

   // A requester just served stays masked until it drops req for a cycle.
   assign elig = bus.req & ~done;
   assign take = (state == ST_IDLE) && gnt_any;
   assign bus.busy = (state != ST_IDLE);

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req     (elig),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (gnt_any) state_nx = ST_GRANT;
         ST_GRANT: state_nx = ST_RESP;
         ST_RESP:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      rsp_data_nx = 8'h00;
      rsp_err_nx  = 1'b0;
      if (lat_we) begin
         if (lat_addr == ADDR_SCRATCH) rsp_data_nx = lat_wdata;
         else                          rsp_err_nx  = 1'b1;
      end else begin
         case (lat_addr)
            ADDR_ID:      rsp_data_nx = ID_VALUE;
            ADDR_REV:     rsp_data_nx = REV_VALUE;
            ADDR_SCRATCH: rsp_data_nx = scratch;
            default:      rsp_data_nx = status;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr           <= '0;
         idx           <= '0;
         done          <= '0;
         lat_we        <= 1'b0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         scratch       <= '0;
         status        <= '0;
         bus.rsp_valid <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
`ifdef ID_PARITY_EN
         bus.rsp_par   <= 1'b0;
`endif
      end else begin
         bus.rsp_valid <= '0;
         done          <= (done & bus.req) | (take ? gnt : '0);
         if (take) begin
            idx       <= gnt_idx;
            lat_we    <= bus.we[gnt_idx];
            lat_addr  <= bus.addr[gnt_idx*2 +: 2];
            lat_wdata <= bus.wdata[gnt_idx*8 +: 8];
         end
         if (state == ST_GRANT) begin
            status           <= status + 8'd1;
            if (lat_we && lat_addr == ADDR_SCRATCH) scratch <= lat_wdata;
            bus.rsp_valid[idx] <= 1'b1;
            bus.rsp_data     <= rsp_data_nx;
            bus.rsp_err      <= rsp_err_nx;
`ifdef ID_PARITY_EN
            bus.rsp_par      <= ^rsp_data_nx;
`endif
         end
         if (state == ST_RESP)
            ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule
